// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, op
// classification helpers and the controller state type.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULH  = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd4;
    localparam logic [2:0] MD_MOD   = 3'd5;
    localparam logic [2:0] MD_DIVU  = 3'd6;
    localparam logic [2:0] MD_MODU  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Divide-class ops all live in the upper half of the encoding space.
    function automatic logic md_op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_op_is_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_MOD);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it fits.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = ~diff[WIDTH];
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide unit for the EXE stage: shift-add multiply with
// MUL_BITS bits per cycle, restoring radix-2 divide, sign fix at the end.
//
// state | meaning
// IDLE  | ready for a new op (in_ready=1)
// CALC  | iterating; counter counts down to the final step
// DONE  | result held on out_result until consumed or flushed
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2,
    parameter int FAST_DIV = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int CNT_W     = $clog2(WIDTH) + 1;
    localparam int MUL_ITERS = WIDTH / MUL_BITS;
    localparam int PP_W      = WIDTH + MUL_BITS;

    md_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       op_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] res_q;

    logic             accept;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] fast_res;

    logic [PP_W-1:0]  pp;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH-1:0] div_rem_n;
    logic             div_q_bit;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH-1:0] final_res;
    logic             last_iter;

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign accept     = in_valid & in_ready & ~flush;
    assign last_iter  = (cnt_q == CNT_W'(1));

    // Operand conditioning at accept: signed ops iterate on magnitudes.
    always_comb begin
        src1_neg = md_op_is_signed(in_op) & in_src1[WIDTH-1];
        src2_neg = md_op_is_signed(in_op) & in_src2[WIDTH-1];
        a_mag    = src1_neg ? -in_src1 : in_src1;
        b_mag    = src2_neg ? -in_src2 : in_src2;
        div_zero = (in_src2 == '0);
        div_ovf  = ((in_op == MD_DIV) || (in_op == MD_MOD))
                   && (in_src1 == {1'b1, {(WIDTH-1){1'b0}}})
                   && (in_src2 == '1);
        fast     = (FAST_DIV != 0) && md_op_is_div(in_op) && (div_zero || div_ovf);
        // op[0] set selects the remainder; MIN/-1 quotient is the dividend itself.
        if (in_op[0])
            fast_res = div_zero ? in_src1 : '0;
        else
            fast_res = div_zero ? '1 : in_src1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                    cnt_d   = md_op_is_div(in_op) ? CNT_W'(WIDTH) : CNT_W'(MUL_ITERS);
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Shift-add multiply: hi accumulates, lo holds unconsumed multiplier bits
    // at the bottom and finished product bits shifting in at the top.
    always_comb begin
        pp = {{MUL_BITS{1'b0}}, hi_q};
        for (int k = 0; k < MUL_BITS; k++) begin
            if (lo_q[k])
                pp = pp + (PP_W'(b_q) << k);
        end
        mul_hi_n = pp[PP_W-1:MUL_BITS];
        mul_lo_n = {pp[MUL_BITS-1:0], lo_q[WIDTH-1:MUL_BITS]};
    end

    muldiv_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i     (hi_q),
        .divisor_i (b_q),
        .bit_i     (lo_q[WIDTH-1]),
        .rem_o     (div_rem_n),
        .q_o       (div_q_bit)
    );

    always_comb begin
        if (md_op_is_div(op_q)) begin
            hi_n = div_rem_n;
            lo_n = {lo_q[WIDTH-2:0], div_q_bit};
        end else begin
            hi_n = mul_hi_n;
            lo_n = mul_lo_n;
        end
    end

    // Sign fix on the final step; the high word of a negated double-width
    // product only needs a carry in when the low word is zero.
    always_comb begin
        final_res = '0;
        case (op_q)
            MD_MUL:   final_res = lo_n;
            MD_MULH:  final_res = neg_q ? (~hi_n + WIDTH'(lo_n == '0)) : hi_n;
            MD_MULHU: final_res = hi_n;
            MD_DIV,
            MD_DIVU:  final_res = dz_q ? '1 : (neg_q ? -lo_n : lo_n);
            MD_MOD,
            MD_MODU:  final_res = rem_neg_q ? -hi_n : hi_n;
            default:  final_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_q     <= '0;
        end else if (accept) begin
            op_q      <= in_op;
            neg_q     <= src1_neg ^ src2_neg;
            rem_neg_q <= src1_neg;
            dz_q      <= div_zero;
            b_q       <= b_mag;
            hi_q      <= '0;
            lo_q      <= a_mag;
            if (fast)
                res_q <= fast_res;
        end else if ((state_q == CALC) && !flush) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (last_iter)
                res_q <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed self-checking bench for muldiv_iter_unit at WIDTH=32, MUL_BITS=2,
// FAST_DIV=1, with hand-computed results and latencies.
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = MD_MUL;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_iter_unit #(
        .WIDTH(32),
        .MUL_BITS(2),
        .FAST_DIV(1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble the inputs after accept, wait for the result and
    // consume it. lat counts cycles from accept to out_valid visible.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = MD_MULHU;
        in_src1  = 32'hDEAD_BEEF;
        in_src2  = 32'h1357_9BDF;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", out_result);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [5]  = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULH, MD_MUL};
        logic [31:0] as  [5]  = '{32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [5]  = '{32'h0000_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        logic [31:0] exp [5]  = '{32'h0626_0060, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 17) begin
                errors++;
                $display("FAIL mul_latency[%0d]: got %0d expected 17", i, lat);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{MD_DIV, MD_MOD, MD_DIVU, MD_MODU, MD_DIV, MD_MOD};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0007, 32'h0000_0007};
        logic [31:0] bs  [6] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0001};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops [6] = '{MD_DIVU, MD_MOD, MD_DIV, MD_MOD, MD_DIV, MD_MOD};
        logic [31:0] as  [6] = '{32'h0000_0005, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] bs  [6] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL fast_result[%0d]: got %h expected %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL fast_latency[%0d]: got %0d expected 1", i, lat);
            end
        end
    endtask

    task automatic test_flush_calc();
        logic [31:0] res;
        int lat;
        logic seen;
        in_valid = 1'b1;
        in_op    = MD_DIV;
        in_src1  = 32'd100;
        in_src2  = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL flush_calc_idle: got rdy/busy=%b expected 10", {in_ready, busy});
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_no_valid: got out_valid seen=%b expected 0", seen);
        end
        run_op(MD_MUL, 32'd3, 32'd4, res, lat);
        checks++;
        if (res !== 32'd12) begin
            errors++;
            $display("FAIL flush_then_mul: got %h expected 0000000c", res);
        end
    endtask

    task automatic test_flush_idle();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = MD_MUL;
        in_src1  = 32'd2;
        in_src2  = 32'd2;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL flush_idle_reject: got rdy/busy=%b expected 10", {in_ready, busy});
        end
    endtask

    task automatic test_flush_done();
        int n;
        in_valid = 1'b1;
        in_op    = MD_MUL;
        in_src1  = 32'd3;
        in_src2  = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_reach: got out_valid=%b expected 1", out_valid);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_done_discard: got vld/rdy=%b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_pressure();
        int n;
        in_valid = 1'b1;
        in_op    = MD_MUL;
        in_src1  = 32'h0000_1234;
        in_src2  = 32'h0000_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_op    = MD_DIV;
        in_src1  = 32'd9;
        in_src2  = 32'd3;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_result !== 32'h0626_0060) begin
                errors++;
                $display("FAIL hold_done[%0d]: got vld/rdy=%b result=%h expected 10 06260060",
                         c, {out_valid, in_ready}, out_result);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: got vld/busy=%b expected 00", {out_valid, busy});
        end
        checks++;
        if (out_result !== 32'h0626_0060) begin
            errors++;
            $display("FAIL result_after_handshake: got %h expected 06260060", out_result);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_op    = MD_DIV;
        in_src1  = 32'd1000;
        in_src2  = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got rdy/vld/busy=%b result=%h expected 100 00000000",
                     {in_ready, out_valid, busy}, out_result);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL after_reset_idle: got rdy/busy=%b expected 10", {in_ready, busy});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        @(posedge clk); #1;
        test_mul();
        test_div();
        test_fast_path();
        test_flush_calc();
        test_flush_idle();
        test_flush_done();
        test_back_pressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
